// File: rtl/truth_table_sweeper.sv
// Steps an N_IN-input combinational block through every input combination in ascending order,
// records its output after a settle delay, and grades the measured truth table against an expected vector.
module truth_table_sweeper #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [2**N_IN-1:0]   expected,
   input  logic                 y_in,
   output logic [N_IN-1:0]      combo_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2**N_IN-1:0]   table_out,
   output logic [N_IN-1:0]      fail_idx
);

   localparam int              W           = 2**N_IN;
   localparam logic [N_IN-1:0] LAST_IDX    = {N_IN{1'b1}};
   localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [N_IN-1:0] idx_q, idx_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [W-1:0]    exp_q, exp_d;
   logic [W-1:0]    table_q, table_d;
   logic            pass_q, pass_d;
   logic [N_IN-1:0] fail_q, fail_d;

   // Table as it will look once the current sample lands, so grading on the
   // DONE-entry edge already includes the final combination.
   logic [W-1:0]    table_next;
   logic [W-1:0]    diff;
   logic [N_IN-1:0] first_idx;

   always_comb begin
      table_next        = table_q;
      table_next[idx_q] = y_in;
      diff              = table_next ^ exp_q;
      first_idx         = '0;
      // Scanning downward lets the lowest mismatching index win.
      for (int i = W - 1; i >= 0; i--) begin
         if (diff[i]) first_idx = N_IN'(i);
      end
   end

   // NOTE: every signal assigned in this block gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      table_d = table_q;
      pass_d  = pass_q;
      fail_d  = fail_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               exp_d   = expected;
               table_d = '0;
               pass_d  = 1'b0;
               fail_d  = '0;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = DRIVE;
            end
         end

         DRIVE: begin
            if (abort) begin
               idx_d   = '0;
               cnt_d   = '0;
               pass_d  = 1'b0;
               state_d = IDLE;
            end else if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               table_d = table_next;
               if (idx_q == LAST_IDX) begin
                  pass_d  = (diff == '0);
                  fail_d  = first_idx;
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + N_IN'(1);
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         DONE: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // updates from pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         exp_q   <= '0;
         table_q <= '0;
         pass_q  <= 1'b0;
         fail_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         table_q <= table_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
      end
   end

   // The index register is the applied combination, so combo_out is glitch-free.
   assign combo_out = idx_q;
   assign busy      = (state_q == DRIVE);
   assign done      = (state_q == DONE);
   assign pass      = pass_q;
   assign table_out = table_q;
   assign fail_idx  = fail_q;

endmodule
